// File: rtl/tx_queue.sv
// tx_queue -- DEPTH-entry transfer FIFO between the memory bus (mbus) and
// the address bus (abus).
//
// Either bus may push a word (active-low load strobes) and either bus may
// pop the head word (active-low out strobes). The head entry is driven
// combinationally onto whichever bus has its out strobe low. The pop takes
// effect at the next rising clk.
//
// Parameters:
//   WIDTH : data width of both buses and of each storage word
//   DEPTH : number of entries (power of two, >= 2)
//   CW    : width of count, $clog2(DEPTH)+1 (derived)
//
// Ports:
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   aloadn  : push abus value at next edge (active low)
//   mloadn  : push mbus value at next edge (active low, wins over aloadn)
//   aoutn   : drive head onto abus, pop at next edge (active low)
//   moutn   : drive head onto mbus, pop at next edge (active low)
//   mbus    : memory bus, tri-stated unless moutn=0
//   abus    : address bus, tri-stated unless aoutn=0
//   empty   : registered, count==0
//   full    : registered, count==DEPTH
//   count   : registered number of valid entries
//
// Optional build macro TX_QUEUE_ERR_FLAGS_EN adds:
//   ovf     : sticky overflow flag (push refused)
//   unf     : sticky underflow flag (pop on empty with no push)
//   errclrn : active-low synchronous clear of ovf/unf (wins over set)
module tx_queue #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          aloadn,
   input  logic          mloadn,
   input  logic          aoutn,
   input  logic          moutn,
   inout  wire [WIDTH-1:0] mbus,
   inout  wire [WIDTH-1:0] abus,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
`ifdef TX_QUEUE_ERR_FLAGS_EN
   ,
   output logic          ovf,
   output logic          unf,
   input  logic          errclrn
`endif
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             empty_reg;
   logic             full_reg;

   logic             push;
   logic             pop;
   logic             eff_push;
   logic             eff_pop;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] head;

   assign push = ~mloadn | ~aloadn;
   assign pop  = ~moutn  | ~aoutn;

   // A pop on an empty queue is never effective, even with a same-cycle
   // push: the new word is kept. A push into a full queue only succeeds
   // when the head leaves at the same edge.
   assign eff_pop  = pop  & (count_reg != '0);
   assign eff_push = push & ((count_reg != CW'(DEPTH)) | pop);

   // mbus has priority when both load strobes are low. For a same-bus
   // load+out this captures the head the queue itself is driving, which
   // rotates the head to the tail.
   assign wr_data = ~mloadn ? mbus : abus;

   // Stale storage is never shown while empty; drive zeros instead.
   assign head = empty_reg ? '0 : mem[rd_ptr_reg];

   assign mbus = moutn ? {WIDTH{1'bz}} : head;
   assign abus = aoutn ? {WIDTH{1'bz}} : head;

   always_comb begin
      count_next = count_reg;
      case ({eff_push, eff_pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
      end else begin
         if (eff_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (eff_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == CW'(DEPTH));
      end
   end

   // When full with push+pop, wr_ptr equals rd_ptr; the old head has
   // already been driven this cycle, so overwriting it at the edge is safe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (eff_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   assign empty = empty_reg;
   assign full  = full_reg;
   assign count = count_reg;

`ifdef TX_QUEUE_ERR_FLAGS_EN
   logic ovf_reg;
   logic unf_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else if (!errclrn) begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
      end else begin
         if (push && !eff_push)                    ovf_reg <= 1'b1;
         if (pop && (count_reg == '0) && !push)    unf_reg <= 1'b1;
      end
   end

   assign ovf = ovf_reg;
   assign unf = unf_reg;
`endif

endmodule
